axi_lite_regbank: RTL and testbench

Parametrised AXI4-Lite slave register bank, the next generation of the single-instance controller slave used by the cube renderer IP. It has a configurable register count, per-byte write strobes and a per-register read-only mask; read-only slots read back live hardware status. Each write produces a one-cycle write pulse to the register it targets. It sits between the PS AXI interconnect and the renderer datapath.

---
 rtl/axi_lite_regbank.sv | 226 ++++++++++++++++++++++
 tb/tb_axi_lite_regbank.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank: AXI4-Lite slave register bank with per-byte write strobes, read-only
// status slots (read from reg_in) and a one-cycle wr_pulse per committed write.
// Latency: BVALID/RVALID one cycle after the completing handshake; reg_out follows the commit.
// Backpressure: one write and one read outstanding; AW/W/AR ready low while a response waits.
// Optional: define AXI_LITE_REGBANK_DECERR_EN to answer SLVERR for out-of-range accesses
// and for writes to read-only slots (default build answers OKAY).
// Ports: S_AXI_* AXI4-Lite slave; reg_out flattened contents (reg i at [32i+31:32i]);
// reg_in status words for read-only slots; wr_pulse one bit per register.
module axi_lite_regbank #(
  parameter int                   C_S_AXI_DATA_WIDTH = 32,
  parameter int                   C_S_AXI_ADDR_WIDTH = 6,
  parameter int                   N_REGS             = 16,
  parameter logic [N_REGS-1:0]    RO_MASK            = '0,
  parameter logic [N_REGS*32-1:0] RESET_VAL          = '0
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [N_REGS*32-1:0]            reg_out,
  input  logic [N_REGS*32-1:0]            reg_in,
  output logic [N_REGS-1:0]               wr_pulse
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  typedef enum logic { W_IDLE = 1'b0, W_RESP = 1'b1 } w_state_e;
  typedef enum logic { R_IDLE = 1'b0, R_DATA = 1'b1 } r_state_e;

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  logic              aw_hold_q, aw_hold_d, w_hold_q, w_hold_d;
  logic [IDX_W-1:0]  awidx_q, awidx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       regs_q [N_REGS];
  logic [31:0]       regs_d [N_REGS];

  logic              aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]  widx, ridx;
  logic [31:0]       wdat, r_val;
  logic [3:0]        wstb;
  logic [1:0]        w_resp, r_resp;

  // AW and W may land in different cycles; a channel already held uses its latched copy.
  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign widx   = aw_hold_q ? awidx_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wdat   = w_hold_q ? wdata_q : S_AXI_WDATA;
  assign wstb   = w_hold_q ? wstrb_q : S_AXI_WSTRB;
  assign ridx   = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign commit = (w_state_q == W_IDLE) && (aw_hold_q || aw_hs) && (w_hold_q || w_hs);

`ifdef AXI_LITE_REGBANK_DECERR_EN
  logic w_err, r_err;
  always_comb begin
    w_err = 1'b1;
    r_err = 1'b1;
    for (int i = 0; i < N_REGS; i++) begin
      if (widx == IDX_W'(i)) w_err = RO_MASK[i];
      if (ridx == IDX_W'(i)) r_err = 1'b0;
    end
  end
  assign w_resp = w_err ? 2'b10 : 2'b00;
  assign r_resp = r_err ? 2'b10 : 2'b00;
`else
  assign w_resp = 2'b00;
  assign r_resp = 2'b00;
`endif

  // Register array update and write pulse; RO and out-of-range targets match no slot.
  always_comb begin
    regs_d   = regs_q;
    wr_pulse = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (commit && !RO_MASK[i] && (widx == IDX_W'(i))) begin
        wr_pulse[i] = 1'b1;
        for (int k = 0; k < 4; k++)
          if (wstb[k]) regs_d[i][8*k +: 8] = wdat[8*k +: 8];
      end
    end
  end

  // Read mux samples the pre-write array, so a same-cycle write is not visible.
  always_comb begin
    r_val = '0;
    for (int i = 0; i < N_REGS; i++)
      if (ridx == IDX_W'(i)) r_val = RO_MASK[i] ? reg_in[32*i +: 32] : regs_q[i];
  end

  // State registers
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_hold_q <= 1'b0;
      w_hold_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= 2'b00;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= RESET_VAL[32*i +: 32];
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_hold_q <= aw_hold_d;
      w_hold_q  <= w_hold_d;
      awidx_q   <= awidx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      regs_q    <= regs_d;
    end
  end

  // Write FSM next state
  always_comb begin
    w_state_d = w_state_q;
    aw_hold_d = aw_hold_q;
    w_hold_d  = w_hold_q;
    awidx_d   = awidx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (commit) begin
          w_state_d = W_RESP;
          aw_hold_d = 1'b0;
          w_hold_d  = 1'b0;
          bresp_d   = w_resp;
        end else begin
          if (aw_hs) begin
            aw_hold_d = 1'b1;
            awidx_d   = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
          end
          if (w_hs) begin
            w_hold_d = 1'b1;
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
          end
        end
      end
      W_RESP: if (S_AXI_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM outputs; readies are held low while reset is asserted.
  always_comb begin
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        S_AXI_AWREADY = !S_AXI_ARESET && !aw_hold_q;
        S_AXI_WREADY  = !S_AXI_ARESET && !w_hold_q;
      end
      W_RESP:  S_AXI_BVALID = 1'b1;
      default: S_AXI_BVALID = 1'b0;
    endcase
  end
  assign S_AXI_BRESP = bresp_q;

  // Read FSM next state
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: if (ar_hs) begin
        r_state_d = R_DATA;
        rdata_d   = r_val;
        rresp_d   = r_resp;
      end
      R_DATA:  if (S_AXI_RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM outputs
  always_comb begin
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (r_state_q)
      R_IDLE:  S_AXI_ARREADY = !S_AXI_ARESET;
      R_DATA:  S_AXI_RVALID  = 1'b1;
      default: S_AXI_RVALID  = 1'b0;
    endcase
  end
  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = rresp_q;

  for (genvar g = 0; g < N_REGS; g++) begin : g_out
    assign reg_out[32*g +: 32] = regs_q[g];
  end

  // Protection bits, byte-offset address bits and writable-slot reg_in bits carry no meaning.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], reg_in};

endmodule

// File: tb/tb_axi_lite_regbank.sv
module tb_axi_lite_regbank;
  localparam int NR = 12;
  localparam logic [NR-1:0]    RO = 12'h008;
  localparam logic [NR*32-1:0] RV = {{((NR-1)*32){1'b0}}, 32'h5A5A0000};
`ifdef AXI_LITE_REGBANK_DECERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [5:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [NR*32-1:0] reg_out, reg_in;
  logic [NR-1:0]    wr_pulse;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axi_lite_regbank #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6), .N_REGS(NR),
    .RO_MASK(RO), .RESET_VAL(RV)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int npulse, output logic [NR-1:0] pmask);
    bit got = 0;
    bit aw_acc, w_acc;
    resp = 2'bxx; npulse = 0; pmask = '0;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (wr_pulse != '0) npulse++;
      pmask |= wr_pulse;
      aw_acc = awvalid && awready;
      w_acc  = wvalid && wready;
      if (bvalid) begin resp = bresp; got = 1; end
      @(posedge clk); #1;
      if (aw_acc) awvalid = 1'b0;
      if (w_acc)  wvalid  = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_done", got, 1);
  endtask

  task automatic do_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit got = 0;
    bit ar_acc;
    d = 'x; resp = 'x;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      ar_acc = arvalid && arready;
      if (rvalid) begin d = rdata; resp = rresp; got = 1; end
      @(posedge clk); #1;
      if (ar_acc) arvalid = 1'b0;
    end
    arvalid = 1'b0;
    chk("rd_done", got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    resp;
    logic [31:0]   d;
    int            np;
    logic [NR-1:0] pm;

    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    reg_in = '0;
    reg_in[3*32 +: 32] = 32'hBEEF0011;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rdy_vld", {awready, wready, arready, bvalid, rvalid}, 5'b0);
    chk("rst_resp", {bresp, rresp}, 4'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_pulse", wr_pulse, 12'h0);
    chk("rst_reg0", reg_out[31:0], 32'h5A5A0000);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;

    // AW and W together, full strobe
    do_write(6'h00, 32'h0101FFFF, 4'hF, resp, np, pm);
    chk("w0_bresp", resp, 2'b00);
    chk("w0_npulse", np, 1);
    chk("w0_pmask", pm, 12'h001);
    do_read(6'h00, d, resp);
    chk("r0_data", d, 32'h0101FFFF);
    chk("r0_resp", resp, 2'b00);

    // W three cycles ahead of AW
    wdata = 32'hABCD0001; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    chk("wfirst_wready", wready, 1);
    @(posedge clk); #1 wvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("wfirst_wait", {bvalid, wready}, 2'b00);
      @(posedge clk); #1;
    end
    awaddr = 6'h04; awvalid = 1'b1;
    @(negedge clk);
    chk("awlate_ready", awready, 1);
    chk("awlate_pulse", wr_pulse, 12'h002);
    chk("awlate_bvalid_early", bvalid, 0);
    @(posedge clk); #1 awvalid = 1'b0;
    @(negedge clk);
    chk("awlate_bvalid", {bvalid, bresp}, 3'b100);
    chk("awlate_reg1", reg_out[63:32], 32'hABCD0001);
    @(posedge clk); #1;

    // Partial strobes
    do_write(6'h08, 32'hDEAD0011, 4'hF, resp, np, pm);
    do_write(6'h08, 32'hFFFFFFFF, 4'b0101, resp, np, pm);
    chk("strb_pmask", pm, 12'h004);
    do_read(6'h08, d, resp);
    chk("strb_data", d, 32'hDEFF00FF);
    do_write(6'h08, 32'h00000000, 4'b0000, resp, np, pm);
    chk("strb0_resp", resp, 2'b00);
    chk("strb0_pmask", pm, 12'h004);
    chk("strb0_reg2", reg_out[95:64], 32'hDEFF00FF);

    // Read-only slot 3
    do_write(6'h0C, 32'h12345678, 4'hF, resp, np, pm);
    chk("ro_bresp", resp, ERR);
    chk("ro_npulse", np, 0);
    do_read(6'h0C, d, resp);
    chk("ro_data", d, 32'hBEEF0011);
    chk("ro_rresp", resp, 2'b00);

    // Out-of-range write
    do_write(6'h3C, 32'hFFFFFFFF, 4'hF, resp, np, pm);
    chk("oorw_bresp", resp, ERR);
    chk("oorw_npulse", np, 0);

    // Out-of-range read with RREADY held low
    araddr = 6'h30; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    chk("oor_arready", arready, 1);
    @(posedge clk); #1 arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("oor_hold", {rvalid, rresp, rdata}, {1'b1, ERR, 32'h0});
      chk("oor_arready_low", arready, 0);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(negedge clk);
    chk("oor_last", rvalid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("oor_done", rvalid, 0);
    @(posedge clk); #1;

    // Same-cycle write commit and read of register 0
    awaddr = 6'h00; awvalid = 1'b1; wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1'b1;
    bready = 1'b1; araddr = 6'h00; arvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    chk("same_pulse", wr_pulse, 12'h001);
    chk("same_arready", arready, 1);
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    chk("same_rdata", {rvalid, rdata}, {1'b1, 32'h0101FFFF});
    chk("same_bvalid", bvalid, 1);
    chk("same_reg0", reg_out[31:0], 32'h77777777);
    @(posedge clk); #1;

    // Reset while BVALID is pending
    bready = 1'b0; awaddr = 6'h04; awvalid = 1'b1; wdata = 32'h2468ACE0; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("mid_bvalid", {bvalid, reg_out[63:32]}, {1'b1, 32'h2468ACE0});
    #1 rst = 1'b1;
    #1;
    chk("mid_bvalid_drop", bvalid, 0);
    chk("mid_reg0", reg_out[31:0], 32'h5A5A0000);
    chk("mid_reg1", reg_out[63:32], 32'h0);
    chk("mid_reg2", reg_out[95:64], 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    do_write(6'h04, 32'h13579BDF, 4'hF, resp, np, pm);
    chk("post_bresp", resp, 2'b00);
    chk("post_pmask", pm, 12'h002);
    chk("post_reg1", reg_out[63:32], 32'h13579BDF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
